multisend: RTL and testbench
============================

// Module: multisend
// PURPOSE
// - Serialises a 32-bit value onto a 3-bit parallel data bus (out2..out0) with a strobe (controlOut).
// - Sends one octal digit (3 bits) per frame, LSB digit first: 11 frames per word.
// - Frame 10 carries num[31:30], with out2 = 0.
// - Keylock transmitter: enabled starts a transfer; done reports completion to the controller.
// PARAMETERS
// - NUM_DIGITS     default 11  frames per word; ceil(32/3).
// - SETUP_CYCLES   default 1   cycles data is stable before the strobe rises (>=1).
// - STROBE_CYCLES  default 1   cycles controlOut is held high (>=1).
// - HOLD_CYCLES    default 1   cycles data is held after the strobe falls (>=1).
// PORTS
// - hwclk       in   1   system clock; all state changes on the rising edge.
// - rst_n       in   1   asynchronous, active-low reset.
// - num         in   32  value to send; latched when a transfer starts.
// - enabled     in   1   level request; high starts or continues a transfer, low aborts or clears it.
// - out0        out  1   data bit 0 of the current digit.
// - out1        out  1   data bit 1 of the current digit.
// - out2        out  1   data bit 2 of the current digit.
// - controlOut  out  1   strobe; the receiver samples out2..out0 while it is high.
// - done        out  1   high once all NUM_DIGITS frames have been sent.
// BEHAVIOUR
// - All outputs are registered. Reset (rst_n=0, async) -> state IDLE; out0..2, controlOut, done all 0.
// - Internal state: 32-bit shift register sh, digit counter dig (4b), cycle counter cnt.
// - IDLE
//   - Outputs 0.
//   - On enabled=1: sh<=num, dig<=0, go to SETUP.
// - SETUP
//   - {out2,out1,out0}=sh[2:0], controlOut=0.
//   - After SETUP_CYCLES, go to STROBE.
// - STROBE
//   - Data unchanged, controlOut=1.
//   - After STROBE_CYCLES, go to HOLD.
// - HOLD
//   - Data unchanged, controlOut=0.
//   - After HOLD_CYCLES: if dig==NUM_DIGITS-1, go to DONE.
//   - Otherwise sh<=sh>>3 (zero fill), dig<=dig+1, go to SETUP.
// - DONE
//   - done=1; data and controlOut=0.
//   - Stays in DONE while enabled=1. When enabled=0, go to IDLE; done clears on the same edge.
// - Abort: enabled=0 sampled in SETUP, STROBE or HOLD -> IDLE on that edge.
//   - All outputs 0; done is not asserted.
// - Input handling:
//   - num changes after the start edge are ignored until the next transfer.
//   - enabled held high after DONE does not restart; a new transfer needs enabled low for >=1 cycle.
// - Latency (defaults): enabled sampled high at edge E0.
//   - Frame k: SETUP at E(3k), strobe high E(3k+1)..E(3k+2).
//   - done rises at E33 (33 edges after E0).
// - Data never changes while controlOut=1 or in the cycle it falls.
// TESTING
// - Reset mid-transfer (rst_n low async) -> all outputs 0 immediately, state IDLE; no glitch on release.
// - num=555116 (octal 2074514), enabled=1:
//   - 11 strobes.
//   - Digits on {out2,out1,out0} at each strobe: 4,5,1,4,7,0,2,0,0,0,0.
//   - done=1 at E33.
// - num=32'hFFFFFFFF: digits 7 x10 then 3 (out2=0); done after 11 strobes.
// - Drop enabled during frame 5 -> IDLE next edge.
//   - Outputs 0, done stays 0.
//   - Re-raising enabled restarts from digit 0 with num latched again.
// - Hold enabled=1 after done for 10 cycles:
//   - done stays 1, no further strobes.
//   - enabled=0 -> done=0 next edge.
// - Change num mid-transfer (555116 -> 0) -> transmitted digits still 4,5,1,4,7,0,2,0,0,0,0.

Source files
------------

// File: rtl/multisend_if.sv
// Handshake bundle between the controller and the octal-digit transmitter:
// request side (num/enabled) and the parallel data bus with strobe and done.
interface multisend_if;
    logic [31:0] num;
    logic        enabled;
    logic        out0;
    logic        out1;
    logic        out2;
    logic        controlOut;
    logic        done;

    modport master (output num, output enabled,
                    input  out0, input out1, input out2, input controlOut, input done);
    modport slave  (input  num, input  enabled,
                    output out0, output out1, output out2, output controlOut, output done);
endinterface

// File: rtl/multisend.sv
// Keylock transmitter: sends a latched 32-bit word as NUM_DIGITS octal digits,
// LSB digit first, each framed by setup / strobe / hold phases.
module multisend #(
    parameter int NUM_DIGITS    = 11,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic          hwclk,
    input  logic          rst_n,
    multisend_if.slave    bus
);
    localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES) ?
                          ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                          ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_sh,    w_sh_nxt;
    logic [3:0]    r_dig,   w_dig_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]    r_data;
    logic          r_ctrl;
    logic          r_done;
    logic          w_busy_nxt;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_dig   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_ctrl  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sh    <= w_sh_nxt;
            r_dig   <= w_dig_nxt;
            r_cnt   <= w_cnt_nxt;
            // Outputs are registered from the next state so they line up with it.
            r_data  <= w_busy_nxt ? w_sh_nxt[2:0] : 3'b000;
            r_ctrl  <= (w_state_nxt == S_STROBE);
            r_done  <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_dig_nxt   = r_dig;
        w_cnt_nxt   = r_cnt + CW'(1);
        case (r_state)
            S_IDLE: begin
                if (bus.enabled) begin
                    w_sh_nxt    = bus.num;
                    w_dig_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!bus.enabled)                          w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(SETUP_CYCLES - 1))   w_state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (!bus.enabled)                          w_state_nxt = S_IDLE;
                else if (r_cnt == CW'(STROBE_CYCLES - 1))  w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!bus.enabled) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
                    if (r_dig == 4'(NUM_DIGITS - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_sh_nxt    = r_sh >> 3;
                        w_dig_nxt   = r_dig + 4'd1;
                        w_state_nxt = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                // Held until enabled drops, so a stuck-high request never restarts.
                if (!bus.enabled) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != r_state || r_state == S_IDLE || r_state == S_DONE)
            w_cnt_nxt = '0;
    end

    assign w_busy_nxt = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                        (w_state_nxt == S_HOLD);

    assign bus.out0       = r_data[0];
    assign bus.out1       = r_data[1];
    assign bus.out2       = r_data[2];
    assign bus.controlOut = r_ctrl;
    assign bus.done       = r_done;
endmodule

// File: tb/tb_multisend.sv
// Self-checking bench for multisend: cycle-accurate expected outputs come from
// a frame/phase arithmetic model of the default timing (3 cycles per digit).
module tb_multisend;
    logic hwclk = 1'b0;
    logic rst_n = 1'b0;

    multisend_if bus();
    multisend dut (.hwclk(hwclk), .rst_n(rst_n), .bus(bus.slave));

    always #5 hwclk = ~hwclk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [2:0] strb_q[$];
    logic       prev_ctrl;
    logic [2:0] exp_d [11] = '{3'd4, 3'd5, 3'd1, 3'd4, 3'd7, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};

    wire [4:0] w_obs = {bus.done, bus.controlOut, bus.out2, bus.out1, bus.out0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {done, strobe, data} c edges after the start edge.
    function automatic logic [4:0] model(input logic [31:0] v, input int c);
        logic [31:0] s;
        if (c >= 33) return 5'b10000;
        s = v >> (3 * (c / 3));
        return {1'b0, ((c % 3) == 1), s[2:0]};
    endfunction

    task automatic watch();
        if (w_obs[3] && !prev_ctrl) strb_q.push_back(w_obs[2:0]);
        prev_ctrl = w_obs[3];
    endtask

    // Called just after a rising edge with the DUT idle and enabled low.
    task automatic run_word(input string tag, input logic [31:0] val,
                            input int abort_at, input int chg_at, input int hold_n);
        int last;
        strb_q.delete();
        prev_ctrl   = 1'b0;
        bus.num     = val;
        bus.enabled = 1'b1;
        last = (abort_at >= 0) ? abort_at : 33 + hold_n;
        for (int c = 0; c <= last; c++) begin
            @(posedge hwclk); #1;
            watch();
            chk($sformatf("%s c%0d", tag, c), 32'(w_obs), 32'(model(val, c)));
            if (c == chg_at)   bus.num = 32'h0;
            if (c == abort_at) bus.enabled = 1'b0;
        end
        if (abort_at < 0) begin
            chk($sformatf("%s strobes", tag), strb_q.size(), 11);
            bus.enabled = 1'b0;
        end
        @(posedge hwclk); #1;
        chk($sformatf("%s drop", tag), 32'(w_obs), 32'h0);
        @(posedge hwclk); #1;
        chk($sformatf("%s idle", tag), 32'(w_obs), 32'h0);
    endtask

    task automatic chk_digits(input string tag);
        for (int k = 0; k < 11; k++)
            chk($sformatf("%s digit%0d", tag, k),
                (k < strb_q.size()) ? 32'(strb_q[k]) : 32'hDEAD, 32'(exp_d[k]));
    endtask

    initial begin
        bus.num     = 32'h0;
        bus.enabled = 1'b0;
        #1;
        chk("reset outputs", 32'(w_obs), 32'h0);
        @(negedge hwclk) rst_n = 1'b1;
        @(posedge hwclk); #1;
        chk("post reset idle", 32'(w_obs), 32'h0);

        run_word("n555116", 32'd555116, -1, -1, 0);
        chk_digits("n555116");

        run_word("allones", 32'hFFFF_FFFF, -1, -1, 0);
        chk("allones last digit", 32'(strb_q[$]), 32'd3);

        run_word("abort", 32'd555116, 16, -1, 0);
        chk("abort strobes", strb_q.size(), 6);
        run_word("restart", 32'd555116, -1, -1, 0);
        chk_digits("restart");

        run_word("hold", 32'h1234_5678, -1, -1, 10);

        run_word("numchg", 32'd555116, -1, 5, 0);
        chk_digits("numchg");

        // Asynchronous reset in the middle of frame 3.
        bus.num     = 32'hA5A5_5A5A;
        bus.enabled = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(posedge hwclk); #1;
            chk($sformatf("pre-rst c%0d", c), 32'(w_obs), 32'(model(32'hA5A5_5A5A, c)));
        end
        #2 rst_n = 1'b0;
        #1 chk("async reset", 32'(w_obs), 32'h0);
        bus.enabled = 1'b0;
        @(negedge hwclk) rst_n = 1'b1;
        @(posedge hwclk); #1;
        chk("rst release", 32'(w_obs), 32'h0);
        @(posedge hwclk); #1;
        chk("rst idle", 32'(w_obs), 32'h0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            int ab;
            v  = $urandom;
            ab = (i % 2) ? int'($urandom_range(0, 32)) : -1;
            run_word($sformatf("rnd%0d", i), v, ab, int'($urandom_range(0, 32)),
                     int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
